// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a pipeline request port and a
// single-ported synchronous RAM. It handles lane placement for stores,
// extraction and extension for loads, and alignment checking. A store that
// hits the MMIO edge word produces a one-cycle strobe alongside the write.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// ISSUE | address (and store lanes) presented to the RAM
// WAIT  | load only: RAM read data arrives and is captured
// RESP  | one-cycle completion pulse on rsp_valid
module mem_access_unit #(
    parameter logic [31:0] MMIO_ADDR = 32'h00000FFC,
    parameter int          SIZE_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       mem_addr,
    output logic [3:0]        mem_web,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              mmio_strobe
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [SIZE_W-1:0] SZ_BYTE = SIZE_W'(0);
    localparam logic [SIZE_W-1:0] SZ_HALF = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] SZ_WORD = SIZE_W'(2);

    logic [1:0]        state;
    logic              lat_we;
    logic              lat_unsigned;
    logic [SIZE_W-1:0] lat_size;
    logic [1:0]        lat_addr_lo;

    logic              accept;
    logic              misaligned;
    logic [3:0]        st_web;
    logic [31:0]       st_din;
    logic [31:0]       ld_shifted;
    logic [31:0]       ld_data;

    assign req_ready = (state == S_IDLE) && !reset;
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;

    // Alignment check on the incoming request; size 11 is always an error.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Store lane enables and replicated write data for the incoming request.
    always_comb begin
        st_web = 4'b1111;
        st_din = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                st_web = 4'b0001 << req_addr[1:0];
                st_din = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_web = 4'b0011 << {req_addr[1], 1'b0};
                st_din = {2{req_wdata[15:0]}};
            end
            default: begin
                st_web = 4'b1111;
                st_din = req_wdata;
            end
        endcase
    end

    // Load lane select and sign/zero extension using the latched request.
    always_comb begin
        ld_shifted = 32'd0;
        ld_data    = mem_dout;
        case (lat_size)
            SZ_BYTE: begin
                ld_shifted = mem_dout >> {lat_addr_lo, 3'b000};
                ld_data    = {{24{ld_shifted[7] & ~lat_unsigned}}, ld_shifted[7:0]};
            end
            SZ_HALF: begin
                ld_shifted = mem_dout >> {lat_addr_lo[1], 4'b0000};
                ld_data    = {{16{ld_shifted[15] & ~lat_unsigned}}, ld_shifted[15:0]};
            end
            default: begin
                ld_shifted = mem_dout;
                ld_data    = mem_dout;
            end
        endcase
    end

    // Sequencer plus registered RAM-side outputs and held response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= '0;
            lat_addr_lo  <= 2'b00;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            mem_addr     <= 32'd0;
            mem_web      <= 4'b0000;
            mem_din      <= 32'd0;
            mmio_strobe  <= 1'b0;
        end else begin
            // Write-side outputs are single-cycle: only live during ISSUE.
            mem_web     <= 4'b0000;
            mem_din     <= 32'd0;
            mmio_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_unsigned <= req_unsigned;
                        lat_size     <= req_size;
                        lat_addr_lo  <= req_addr[1:0];
                        if (misaligned) begin
                            state     <= S_RESP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state    <= S_ISSUE;
                            mem_addr <= req_addr;
                            if (req_we) begin
                                mem_web     <= st_web;
                                mem_din     <= st_din;
                                mmio_strobe <= (req_addr[31:2] == MMIO_ADDR[31:2]);
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (lat_we) begin
                        state     <= S_RESP;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state     <= S_RESP;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ld_data;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_web;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mmio_strobe;

    int passed = 0;
    int total  = 0;

    logic [31:0] ram [0:1023];

    // per-cycle observations after a request, cycles 1..4
    logic        o_rv  [1:4];
    logic        o_err [1:4];
    logic [31:0] o_rd  [1:4];
    logic [3:0]  o_web [1:4];
    logic [31:0] o_din [1:4];
    logic        o_stb [1:4];
    logic [31:0] o_adr [1:4];
    logic        o_rdy [1:4];
    logic        o_rdy0;

    mem_access_unit #(.MMIO_ADDR(32'h00000FFC), .SIZE_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_web(mem_web), .mem_din(mem_din),
        .mem_dout(mem_dout), .mmio_strobe(mmio_strobe)
    );

    always #5 clk = ~clk;

    // read-first synchronous RAM with byte write enables
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_web[i]) ram[mem_addr[11:2]][8*i +: 8] <= mem_din[8*i +: 8];
        mem_dout <= ram[mem_addr[11:2]];
    end

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        o_rdy0 = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            o_rv[k] = rsp_valid; o_err[k] = rsp_err; o_rd[k] = rsp_rdata;
            o_web[k] = mem_web; o_din[k] = mem_din; o_stb[k] = mmio_strobe;
            o_adr[k] = mem_addr; o_rdy[k] = req_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); else passed++;
        total++; if ({rsp_err, rsp_rdata, mem_addr, mem_web, mem_din, mmio_strobe} !== 102'd0)
            $display("FAIL reset_outputs err=%b rd=%h adr=%h web=%b din=%h stb=%b want all 0",
                     rsp_err, rsp_rdata, mem_addr, mem_web, mem_din, mmio_strobe);
        else passed++;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", req_ready); else passed++;
    endtask

    task automatic test_word();
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEBABE);
        total++; if (o_rdy0 !== 1'b1) $display("FAIL word_st_ready0 got=%b want=1", o_rdy0); else passed++;
        total++; if (o_web[1] !== 4'b1111) $display("FAIL word_st_web got=%b want=1111", o_web[1]); else passed++;
        total++; if (o_din[1] !== 32'hCAFEBABE) $display("FAIL word_st_din got=%h want=cafebabe", o_din[1]); else passed++;
        total++; if (o_adr[1] !== 32'h40) $display("FAIL word_st_addr got=%h want=40", o_adr[1]); else passed++;
        total++; if ({o_rv[1], o_rv[2], o_rv[3]} !== 3'b010) $display("FAIL word_st_rv got=%b want=010", {o_rv[1], o_rv[2], o_rv[3]}); else passed++;
        total++; if (o_web[2] !== 4'b0000) $display("FAIL word_st_web_after got=%b want=0000", o_web[2]); else passed++;
        total++; if ({o_err[2], o_rd[2]} !== 33'd0) $display("FAIL word_st_rsp err=%b rd=%h want 0/0", o_err[2], o_rd[2]); else passed++;
        total++; if (o_rdy[2] !== 1'b0 || o_rdy[3] !== 1'b1) $display("FAIL word_st_ready_seq got=%b%b want=01", o_rdy[2], o_rdy[3]); else passed++;
        total++; if (o_stb[1] !== 1'b0) $display("FAIL word_st_no_strobe got=%b want=0", o_stb[1]); else passed++;
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        total++; if (o_web[1] !== 4'b0000 || o_adr[1] !== 32'h40) $display("FAIL word_ld_issue web=%b adr=%h want 0000/40", o_web[1], o_adr[1]); else passed++;
        total++; if ({o_rv[1], o_rv[2], o_rv[3], o_rv[4]} !== 4'b0010) $display("FAIL word_ld_rv got=%b want=0010", {o_rv[1], o_rv[2], o_rv[3], o_rv[4]}); else passed++;
        total++; if (o_rd[3] !== 32'hCAFEBABE || o_err[3] !== 1'b0) $display("FAIL word_ld_data got=%h err=%b want=cafebabe/0", o_rd[3], o_err[3]); else passed++;
        total++; if (o_rd[4] !== 32'hCAFEBABE) $display("FAIL word_ld_hold got=%h want=cafebabe", o_rd[4]); else passed++;
        total++; if (o_stb[1] !== 1'b0) $display("FAIL word_ld_no_strobe got=%b want=0", o_stb[1]); else passed++;
    endtask

    task automatic test_byte();
        run_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h000000A5);
        total++; if (o_web[1] !== 4'b1000) $display("FAIL byte_st_web got=%b want=1000", o_web[1]); else passed++;
        total++; if (o_din[1] !== 32'hA5A5A5A5) $display("FAIL byte_st_din got=%h want=a5a5a5a5", o_din[1]); else passed++;
        run_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h12345678);
        total++; if (o_web[1] !== 4'b0010 || o_din[1] !== 32'h78787878) $display("FAIL byte_st_lane1 web=%b din=%h want 0010/78787878", o_web[1], o_din[1]); else passed++;
        // RAM word 0x40 now A5FE78BE
        run_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
        total++; if (o_rd[3] !== 32'hFFFFFFA5) $display("FAIL byte_ld_signed got=%h want=ffffffa5", o_rd[3]); else passed++;
        run_req(1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
        total++; if (o_rd[3] !== 32'h000000A5) $display("FAIL byte_ld_unsigned got=%h want=000000a5", o_rd[3]); else passed++;
        run_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
        total++; if (o_rd[3] !== 32'h00000078) $display("FAIL byte_ld_lane1 got=%h want=00000078", o_rd[3]); else passed++;
        run_req(1'b0, 2'b00, 1'b0, 32'h42, 32'h0);
        total++; if (o_rd[3] !== 32'hFFFFFFFE) $display("FAIL byte_ld_lane2 got=%h want=fffffffe", o_rd[3]); else passed++;
    endtask

    task automatic test_half();
        run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'hDEAD8001);
        total++; if (o_web[1] !== 4'b1100 || o_din[1] !== 32'h80018001) $display("FAIL half_st_lanes web=%b din=%h want 1100/80018001", o_web[1], o_din[1]); else passed++;
        // RAM word 0x40 now 800178BE
        run_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
        total++; if (o_rd[3] !== 32'hFFFF8001) $display("FAIL half_ld_signed got=%h want=ffff8001", o_rd[3]); else passed++;
        run_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        total++; if (o_rd[3] !== 32'h00008001) $display("FAIL half_ld_unsigned got=%h want=00008001", o_rd[3]); else passed++;
        run_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
        total++; if (o_rd[3] !== 32'h000078BE) $display("FAIL half_ld_low got=%h want=000078be", o_rd[3]); else passed++;
        run_req(1'b0, 2'b10, 1'b1, 32'h40, 32'h0);
        total++; if (o_rd[3] !== 32'h800178BE) $display("FAIL word_ld_ignores_unsigned got=%h want=800178be", o_rd[3]); else passed++;
    endtask

    task automatic test_misaligned();
        run_req(1'b1, 2'b10, 1'b0, 32'h41, 32'h11111111);
        total++; if (o_rv[1] !== 1'b1 || o_err[1] !== 1'b1) $display("FAIL mis_word_st rv=%b err=%b want 1/1", o_rv[1], o_err[1]); else passed++;
        total++; if (o_web[1] !== 4'b0000 || o_web[2] !== 4'b0000) $display("FAIL mis_word_st_web got=%b/%b want 0000", o_web[1], o_web[2]); else passed++;
        total++; if (o_rd[1] !== 32'd0 || o_rv[2] !== 1'b0) $display("FAIL mis_word_st_rsp rd=%h rv2=%b want 0/0", o_rd[1], o_rv[2]); else passed++;
        total++; if (o_err[3] !== 1'b1 || o_rdy[2] !== 1'b1) $display("FAIL mis_err_hold err=%b rdy=%b want 1/1", o_err[3], o_rdy[2]); else passed++;
        run_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        total++; if (o_rv[1] !== 1'b1 || o_err[1] !== 1'b1) $display("FAIL illegal_size rv=%b err=%b want 1/1", o_rv[1], o_err[1]); else passed++;
        run_req(1'b0, 2'b01, 1'b0, 32'h43, 32'h0);
        total++; if (o_rv[1] !== 1'b1 || o_err[1] !== 1'b1 || o_rd[1] !== 32'd0) $display("FAIL mis_half_ld rv=%b err=%b rd=%h want 1/1/0", o_rv[1], o_err[1], o_rd[1]); else passed++;
        // RAM must be untouched by the rejected store
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        total++; if (o_rd[3] !== 32'h800178BE || o_err[3] !== 1'b0) $display("FAIL mis_no_write got=%h err=%b want 800178be/0", o_rd[3], o_err[3]); else passed++;
    endtask

    task automatic test_mmio();
        run_req(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h4);
        total++; if (o_stb[1] !== 1'b1 || o_stb[2] !== 1'b0) $display("FAIL mmio_word_strobe got=%b%b want=10", o_stb[1], o_stb[2]); else passed++;
        total++; if (o_web[1] !== 4'b1111 || o_din[1] !== 32'h4) $display("FAIL mmio_word_web web=%b din=%h want 1111/4", o_web[1], o_din[1]); else passed++;
        run_req(1'b1, 2'b00, 1'b0, 32'hFFD, 32'h7);
        total++; if (o_stb[1] !== 1'b1) $display("FAIL mmio_byte_strobe got=%b want=1", o_stb[1]); else passed++;
        run_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
        total++; if ({o_stb[1], o_stb[2], o_stb[3]} !== 3'b000) $display("FAIL mmio_load_no_strobe got=%b want=000", {o_stb[1], o_stb[2], o_stb[3]}); else passed++;
        total++; if (o_rd[3] !== 32'h00000704) $display("FAIL mmio_readback got=%h want=00000704", o_rd[3]); else passed++;
        run_req(1'b1, 2'b10, 1'b0, 32'hFF8, 32'h9);
        total++; if (o_stb[1] !== 1'b0) $display("FAIL mmio_neighbour got=%b want=0", o_stb[1]); else passed++;
    endtask

    task automatic test_reset_in_wait();
        logic seen_rv;
        seen_rv = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        @(posedge clk); #1; req_valid = 1'b0;   // cycle 1: ISSUE
        @(posedge clk); #1; reset = 1'b1;       // cycle 2: WAIT
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL rst_wait_ready_in_reset got=%b want=0", req_ready); else passed++;
        @(posedge clk); #1; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen_rv = 1'b1;
            if (k == 0) begin
                total++; if (req_ready !== 1'b1) $display("FAIL rst_wait_ready_after got=%b want=1", req_ready); else passed++;
                total++; if (mem_addr !== 32'd0 || rsp_rdata !== 32'd0) $display("FAIL rst_wait_cleared adr=%h rd=%h want 0/0", mem_addr, rsp_rdata); else passed++;
            end
        end
        total++; if (seen_rv !== 1'b0) $display("FAIL rst_wait_no_rsp got=%b want=0", seen_rv); else passed++;
        // unit still works afterwards
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        total++; if (o_rv[3] !== 1'b1 || o_rd[3] !== 32'h800178BE) $display("FAIL rst_wait_recover rv=%b rd=%h want 1/800178be", o_rv[3], o_rd[3]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_mmio();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
